flappy_ctrl_fsm: RTL and testbench

Parametrised game-flow controller for the Flappy Bird design. It sequences start, fall, rise, hit and game-over states on the VGA frame strobe. It also provides multi-frame flap rise, a life counter with respawn delay, a survival score and an optional pause mode. It sits between the keypad debounce logic and the VGA renderer, which consumes `state`.

---
 rtl/flappy_ctrl_fsm_if.sv | 29 ++
 rtl/flappy_ctrl_fsm.sv | 189 ++++++++++++++++++
 tb/tb_flappy_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/flappy_ctrl_fsm_if.sv
// flappy_ctrl_fsm_if
// Bundles the game-controller inputs (frame strobe, flap key, collision, pause)
// and the registered game outputs consumed by the VGA renderer and LEDs.
// master drives the inputs and observes the outputs. slave is the controller side.
interface flappy_ctrl_fsm_if #(
    parameter int CNT_W   = 3,
    parameter int SCORE_W = 16
);
    logic               VGAfeedback;
    logic               is_up;
    logic               dead;
    logic               pause;
    logic [2:0]         state;
    logic               debounce;
    logic [CNT_W-1:0]   confeedback;
    logic [2:0]         lives;
    logic [SCORE_W-1:0] score;
    logic [3:0]         LED;

    modport master (
        output VGAfeedback, is_up, dead, pause,
        input  state, debounce, confeedback, lives, score, LED
    );

    modport slave (
        input  VGAfeedback, is_up, dead, pause,
        output state, debounce, confeedback, lives, score, LED
    );
endinterface

// File: rtl/flappy_ctrl_fsm.sv
// flappy_ctrl_fsm
// Game-flow controller for Flappy Bird. Every state, counter, score and
// life update happens only on the VGA frame strobe. Flap key edges seen
// between strobes are latched and consumed by the next strobe.
// Optional pause mode: define FLAPPY_PAUSE_EN to enable the PAUSE state.
module flappy_ctrl_fsm #(
    parameter int LIVES          = 3,
    parameter int RISE_FRAMES    = 4,
    parameter int RESPAWN_FRAMES = 30,
    parameter int CNT_W          = 3,
    parameter int SCORE_W        = 16
) (
    input  logic                   CLK,
    input  logic                   SW,
    flappy_ctrl_fsm_if.slave       bus
);

    typedef enum logic [2:0] {
        S_BEGIN = 3'b100,
        S_DOWN  = 3'b001,
        S_UP    = 3'b010,
        S_DEAD  = 3'b011,
        S_HIT   = 3'b101,
        S_PAUSE = 3'b110
    } stateType;

    localparam logic [CNT_W-1:0]   CONF_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [3:0]         RISE_LOAD = 4'(RISE_FRAMES - 1);
    localparam logic [5:0]         RESP_LOAD = 6'(RESPAWN_FRAMES - 1);
    localparam logic [2:0]         LIVES_LD  = 3'(LIVES);

    stateType           r_state;
    stateType           r_savedState;
    logic               r_isUpD;
    logic               r_pend;
    logic [3:0]         r_rise;
    logic [5:0]         r_respawn;
    logic [CNT_W-1:0]   r_conf;
    logic [2:0]         r_lives;
    logic [SCORE_W-1:0] r_score;
    logic               r_debounce;
    logic [3:0]         r_led;

    stateType           w_stateNext;
    stateType           w_savedNext;
    logic [3:0]         w_riseNext;
    logic [5:0]         w_respawnNext;
    logic [CNT_W-1:0]   w_confNext;
    logic [2:0]         w_livesNext;
    logic [SCORE_W-1:0] w_scoreNext;
    logic               w_debounceNext;
    logic [3:0]         w_ledNext;
    logic               w_edge;
    logic               w_flap;
    logic               w_pauseReq;

    assign w_edge = bus.is_up & ~r_isUpD;
    assign w_flap = r_pend | w_edge;

`ifdef FLAPPY_PAUSE_EN
    assign w_pauseReq = bus.pause;
`else
    assign w_pauseReq = 1'b0;
`endif

    // State register: flap edge capture runs every cycle, everything else
    // advances only on the frame strobe; debounce drops on the following cycle.
    always_ff @(posedge CLK or negedge SW) begin
        if (!SW) begin
            r_state      <= S_BEGIN;
            r_savedState <= S_DOWN;
            r_isUpD      <= 1'b0;
            r_pend       <= 1'b0;
            r_rise       <= '0;
            r_respawn    <= '0;
            r_conf       <= '0;
            r_lives      <= LIVES_LD;
            r_score      <= '0;
            r_debounce   <= 1'b0;
            r_led        <= 4'b0001;
        end else begin
            r_isUpD <= bus.is_up;
            if (bus.VGAfeedback) begin
                r_pend       <= 1'b0;
                r_state      <= w_stateNext;
                r_savedState <= w_savedNext;
                r_rise       <= w_riseNext;
                r_respawn    <= w_respawnNext;
                r_conf       <= w_confNext;
                r_lives      <= w_livesNext;
                r_score      <= w_scoreNext;
                r_debounce   <= w_debounceNext;
                r_led        <= w_ledNext;
            end else begin
                r_pend     <= r_pend | w_edge;
                r_debounce <= 1'b0;
            end
        end
    end

    // Next-state and datapath decisions for one strobe; priority is
    // collision, then pause, then flap.
    always_comb begin
        w_stateNext    = r_state;
        w_savedNext    = r_savedState;
        w_riseNext     = r_rise;
        w_respawnNext  = r_respawn;
        w_confNext     = r_conf;
        w_livesNext    = r_lives;
        w_scoreNext    = r_score;
        w_debounceNext = 1'b0;

        if ((r_state == S_DOWN || r_state == S_UP) && r_score != SCORE_MAX) begin
            w_scoreNext = r_score + SCORE_W'(1);
        end

        case (r_state)
            S_BEGIN: begin
                if (w_flap) begin
                    w_stateNext = S_DOWN;
                    w_livesNext = LIVES_LD;
                    w_scoreNext = '0;
                end
            end
            S_DOWN, S_UP: begin
                if (bus.dead) begin
                    w_stateNext   = S_HIT;
                    w_livesNext   = (r_lives != 3'd0) ? r_lives - 3'd1 : 3'd0;
                    w_respawnNext = RESP_LOAD;
                end else if (w_pauseReq) begin
                    w_stateNext = S_PAUSE;
                    w_savedNext = r_state;
                end else if (w_flap) begin
                    w_stateNext    = S_UP;
                    w_riseNext     = RISE_LOAD;
                    w_debounceNext = 1'b1;
                    if (r_conf != CONF_MAX) begin
                        w_confNext = r_conf + CNT_W'(1);
                    end
                end else if (r_state == S_DOWN) begin
                    w_confNext = '0;
                end else if (r_rise == 4'd0) begin
                    w_stateNext = S_DOWN;
                end else begin
                    w_riseNext = r_rise - 4'd1;
                end
            end
            S_HIT: begin
                if (r_respawn == 6'd0) begin
                    w_stateNext = (r_lives == 3'd0) ? S_DEAD : S_DOWN;
                end else begin
                    w_respawnNext = r_respawn - 6'd1;
                end
            end
            S_DEAD: begin
                w_stateNext = S_DEAD;
            end
            S_PAUSE: begin
                if (!w_pauseReq) begin
                    w_stateNext = r_savedState;
                end
            end
            default: begin
                w_stateNext = S_BEGIN;
            end
        endcase
    end

    // LED decode of the state being entered, registered alongside it.
    always_comb begin
        w_ledNext = 4'b0000;
        case (w_stateNext)
            S_BEGIN:        w_ledNext = 4'b0001;
            S_DOWN:         w_ledNext = 4'b0010;
            S_UP:           w_ledNext = 4'b0100;
            S_HIT, S_DEAD:  w_ledNext = 4'b1000;
            default:        w_ledNext = 4'b0000;
        endcase
    end

    assign bus.state       = r_state;
    assign bus.debounce    = r_debounce;
    assign bus.confeedback = r_conf;
    assign bus.lives       = r_lives;
    assign bus.score       = r_score;
    assign bus.LED         = r_led;

endmodule

// File: tb/tb_flappy_ctrl_fsm.sv
// tb_flappy_ctrl_fsm
// Directed bench for flappy_ctrl_fsm with LIVES=3, RISE_FRAMES=4,
// RESPAWN_FRAMES=30, CNT_W=3, SCORE_W=16. Expected values are hand-computed.
// Pause checks follow FLAPPY_PAUSE_EN.
module tb_flappy_ctrl_fsm;

    logic CLK;
    logic SW;
    int   totalChecks;
    int   badChecks;
    int   debCount;
    int   debBase;

    flappy_ctrl_fsm_if #(.CNT_W(3), .SCORE_W(16)) bus ();

    flappy_ctrl_fsm #(
        .LIVES(3), .RISE_FRAMES(4), .RESPAWN_FRAMES(30), .CNT_W(3), .SCORE_W(16)
    ) dut (
        .CLK (CLK),
        .SW  (SW),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per cycle
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count every cycle on which debounce is seen high
    initial debCount = 0;
    always @(negedge CLK) begin
        if (bus.debounce === 1'b1) debCount++;
    end

    // Hard stop in case the run never reaches its summary
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One frame: optional flap edges between strobes, then a one-cycle strobe
    // with dead and optionally a flap edge on the strobe cycle itself.
    // Returns on the falling edge after the strobe, when outputs are settled.
    task automatic applyStimulus(input int nEdges, input bit edgeOnStrobe, input bit deadIn);
        for (int k = 0; k < nEdges; k++) begin
            @(negedge CLK) bus.is_up = 1'b1;
            @(negedge CLK) bus.is_up = 1'b0;
        end
        repeat (2) @(negedge CLK);
        bus.dead        = deadIn;
        bus.VGAfeedback = 1'b1;
        if (edgeOnStrobe) bus.is_up = 1'b1;
        @(negedge CLK);
        bus.VGAfeedback = 1'b0;
        bus.dead        = 1'b0;
        if (edgeOnStrobe) bus.is_up = 1'b0;
    endtask

    initial begin
        totalChecks     = 0;
        badChecks       = 0;
        SW              = 1'b0;
        bus.VGAfeedback = 1'b0;
        bus.is_up       = 1'b0;
        bus.dead        = 1'b0;
        bus.pause       = 1'b0;

        // Reset values
        repeat (3) @(negedge CLK);
        checkOutput("rstState", bus.state, 3'b100);
        checkOutput("rstLed", bus.LED, 4'b0001);
        checkOutput("rstLives", bus.lives, 3);
        checkOutput("rstScore", bus.score, 0);
        checkOutput("rstConf", bus.confeedback, 0);
        checkOutput("rstDeb", bus.debounce, 0);
        SW = 1'b1;

        // Idle in BEGIN without flaps
        repeat (3) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("idleState", bus.state, 3'b100);
        checkOutput("idleLed", bus.LED, 4'b0001);
        checkOutput("idleLives", bus.lives, 3);

        // Start the game, then two DOWN strobes
        debBase = debCount;
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("startState", bus.state, 3'b001);
        checkOutput("startLed", bus.LED, 4'b0010);
        checkOutput("startScore", bus.score, 0);
        checkOutput("startNoDeb", debCount - debBase, 0);
        repeat (2) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("downScore", bus.score, 2);

        // Flap edge on the strobe cycle itself, then rise for RISE_FRAMES
        debBase = debCount;
        applyStimulus(0, 1'b1, 1'b0);
        checkOutput("flapState", bus.state, 3'b010);
        checkOutput("flapDeb", bus.debounce, 1);
        checkOutput("flapConf", bus.confeedback, 1);
        checkOutput("flapLed", bus.LED, 4'b0100);
        checkOutput("flapScore", bus.score, 3);
        repeat (3) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("riseState", bus.state, 3'b010);
        checkOutput("riseDeb", bus.debounce, 0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("fallState", bus.state, 3'b001);
        checkOutput("fallConf", bus.confeedback, 1);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("confClr", bus.confeedback, 0);
        checkOutput("confScore", bus.score, 8);
        checkOutput("oneDeb", debCount - debBase, 1);

        // Two edges between strobes make one flap; a flap while rising reloads
        debBase = debCount;
        applyStimulus(2, 1'b0, 1'b0);
        checkOutput("dblState", bus.state, 3'b010);
        checkOutput("dblConf", bus.confeedback, 1);
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("upFlapConf", bus.confeedback, 2);

        // Key held high gives a single flap only
        @(negedge CLK) bus.is_up = 1'b1;
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        bus.is_up = 1'b0;
        checkOutput("heldConf", bus.confeedback, 3);
        checkOutput("heldDeb", debCount - debBase, 3);

        // Consecutive-flap counter saturates at all-ones
        repeat (5) applyStimulus(1, 1'b0, 1'b0);
        checkOutput("satConf", bus.confeedback, 7);
        checkOutput("satScore", bus.score, 17);
        repeat (4) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("drainState", bus.state, 3'b001);
        checkOutput("drainScore", bus.score, 21);

        // Back into UP with rise counter at 2
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("prePauseScore", bus.score, 23);
        debBase = debCount;
        bus.pause = 1'b1;
`ifdef FLAPPY_PAUSE_EN
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b1);
        repeat (2) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("pauseState", bus.state, 3'b110);
        checkOutput("pauseLed", bus.LED, 4'b0000);
        checkOutput("pauseScore", bus.score, 24);
        checkOutput("pauseNoDeb", debCount - debBase, 0);
        bus.pause = 1'b0;
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("resumeState", bus.state, 3'b010);
        checkOutput("resumeScore", bus.score, 24);
        repeat (2) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("resumeUp", bus.state, 3'b010);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("resumeDown", bus.state, 3'b001);
        checkOutput("resumeScore2", bus.score, 27);
        applyStimulus(1, 1'b0, 1'b0);
`else
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("noPauseState", bus.state, 3'b010);
        checkOutput("noPauseLed", bus.LED, 4'b0100);
        checkOutput("noPauseScore", bus.score, 24);
        bus.pause = 1'b0;
`endif
        checkOutput("preRstUp", bus.state, 3'b010);

        // Asynchronous reset mid-UP, seen before any further clock edge
        @(posedge CLK);
        #2 SW = 1'b0;
        #1;
        checkOutput("asyncState", bus.state, 3'b100);
        checkOutput("asyncLed", bus.LED, 4'b0001);
        checkOutput("asyncScore", bus.score, 0);
        checkOutput("asyncConf", bus.confeedback, 0);
        checkOutput("asyncLives", bus.lives, 3);
        repeat (2) @(negedge CLK);
        SW = 1'b1;
        @(negedge CLK);
        checkOutput("postRstState", bus.state, 3'b100);

        // First hit: dead beats flap on the same strobe
        applyStimulus(1, 1'b0, 1'b0);
        debBase = debCount;
        applyStimulus(1, 1'b0, 1'b1);
        checkOutput("hitState", bus.state, 3'b101);
        checkOutput("hitLives", bus.lives, 2);
        checkOutput("hitLed", bus.LED, 4'b1000);
        checkOutput("hitScore", bus.score, 1);
        for (int i = 0; i < 29; i++) applyStimulus(i % 2, 1'b0, (i % 3) == 0);
        checkOutput("respawnHold", bus.state, 3'b101);
        checkOutput("hitNoDeb", debCount - debBase, 0);
        checkOutput("hitLives2", bus.lives, 2);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("respawnState", bus.state, 3'b001);
        checkOutput("respawnScore", bus.score, 1);

        // Second and third hits, the last one ending the game
        applyStimulus(0, 1'b0, 1'b1);
        repeat (30) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("hit2State", bus.state, 3'b001);
        checkOutput("hit2Lives", bus.lives, 1);
        applyStimulus(0, 1'b0, 1'b1);
        checkOutput("hit3Lives", bus.lives, 0);
        repeat (29) applyStimulus(0, 1'b0, 1'b0);
        checkOutput("hit3Hold", bus.state, 3'b101);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("deadState", bus.state, 3'b011);
        checkOutput("deadLed", bus.LED, 4'b1000);
        repeat (3) applyStimulus(1, 1'b0, 1'b0);
        checkOutput("deadHold", bus.state, 3'b011);
        checkOutput("deadScore", bus.score, 3);
        SW = 1'b0;
        #1;
        checkOutput("deadRst", bus.state, 3'b100);
        checkOutput("deadRstLives", bus.lives, 3);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
